// File: rtl/ldpc_extrinsic_writeback.sv
// LDPC extrinsic writeback: tags accumulator issues, captures result vectors,
// queues them and serializes per-edge writes to the message RAM.
module ldpc_extrinsic_writeback #(
   parameter int NUM_INPUTS  = 6,
   parameter int WIDTH       = 16,
   parameter int NUM_WORDS   = 1024,
   parameter int ACC_LATENCY = 4,
   parameter int FIFO_DEPTH  = 4,
   localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_issue_valid,
   input  logic [ADDR_WIDTH-1:0]       i_issue_base_addr,
   output logic                        o_issue_ready,
   input  logic [NUM_INPUTS*WIDTH-1:0] i_acc_data,
   output logic                        o_wr_valid,
   output logic [ADDR_WIDTH-1:0]       o_wr_addr,
   output logic [WIDTH-1:0]            o_wr_data,
   input  logic                        i_wr_ready,
   output logic                        o_idle
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int KW = $clog2(NUM_INPUTS);
   localparam int VW = NUM_INPUTS * WIDTH;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t state, state_next;

   logic [CW-1:0] credits;
   logic          issue_fire;
   logic          push;
   logic          pop;
   logic          send;
   logic          last_word;

   logic [ACC_LATENCY-1:0] tag_valid;
   logic [ADDR_WIDTH-1:0]  tag_addr [ACC_LATENCY];

   logic [VW-1:0]         fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           count, count_next;

   logic [KW-1:0]         k, k_next;
   logic [VW-1:0]         head_data;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [ADDR_WIDTH:0]   addr_sum;
   logic [ADDR_WIDTH:0]   addr_wrap;

   assign o_issue_ready = !i_reset && (credits < CW'(FIFO_DEPTH));
   assign issue_fire    = i_issue_valid && o_issue_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         tag_valid <= '0;
         for (int i = 0; i < ACC_LATENCY; i++)
            tag_addr[i] <= '0;
      end else begin
         tag_valid[0] <= issue_fire;
         tag_addr[0]  <= i_issue_base_addr;
         for (int i = 1; i < ACC_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_addr[i]  <= tag_addr[i-1];
         end
      end
   end

   assign push      = tag_valid[ACC_LATENCY-1];
   assign send      = (state == SEND);
   assign last_word = (k == KW'(NUM_INPUTS - 1));
   assign pop       = send && i_wr_ready && last_word;

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge i_clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= i_acc_data;
         fifo_addr[wr_ptr] <= tag_addr[ACC_LATENCY-1];
      end
   end

   assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         credits <= '0;
      else if (issue_fire && !pop)
         credits <= credits + CW'(1);
      else if (pop && !issue_fire)
         credits <= credits - CW'(1);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_next;
         k     <= k_next;
      end
   end

   // Leaving IDLE on the push itself puts the first word out one cycle after capture.
   always_comb begin
      state_next = state;
      k_next     = k;
      unique case (state)
         IDLE: begin
            if (count_next != '0) begin
               state_next = SEND;
               k_next     = '0;
            end
         end
         SEND: begin
            if (i_wr_ready) begin
               if (last_word) begin
                  k_next     = '0;
                  state_next = (count_next != '0) ? SEND : IDLE;
               end else begin
                  k_next = k + KW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            k_next     = '0;
         end
      endcase
   end

   assign head_data = fifo_data[rd_ptr];
   assign head_addr = fifo_addr[rd_ptr];
   assign addr_sum  = {1'b0, head_addr} + (ADDR_WIDTH+1)'(k);
   assign addr_wrap = (addr_sum >= (ADDR_WIDTH+1)'(NUM_WORDS))
                    ? addr_sum - (ADDR_WIDTH+1)'(NUM_WORDS)
                    : addr_sum;

   assign o_wr_valid = send;
   assign o_wr_addr  = send ? addr_wrap[ADDR_WIDTH-1:0] : '0;
   assign o_wr_data  = send ? head_data[int'(k)*WIDTH +: WIDTH] : '0;

   assign o_idle = (credits == '0) && !send && !issue_fire;

endmodule

// File: tb/tb_ldpc_extrinsic_writeback.sv
// Directed bench for ldpc_extrinsic_writeback with hand-computed
// write sequences for single, wrap, credit, backpressure and reset cases.
module tb_ldpc_extrinsic_writeback;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_issue_valid;
   logic [9:0]  i_issue_base_addr;
   logic        o_issue_ready;
   logic [95:0] i_acc_data;
   logic        o_wr_valid;
   logic [9:0]  o_wr_addr;
   logic [15:0] o_wr_data;
   logic        i_wr_ready;
   logic        o_idle;

   int checks = 0;
   int errors = 0;
   int hits;
   int ev_i, ev_k;

   ldpc_extrinsic_writeback dut (
      .i_clock           (i_clock),
      .i_reset           (i_reset),
      .i_issue_valid     (i_issue_valid),
      .i_issue_base_addr (i_issue_base_addr),
      .o_issue_ready     (o_issue_ready),
      .i_acc_data        (i_acc_data),
      .o_wr_valid        (o_wr_valid),
      .o_wr_addr         (o_wr_addr),
      .o_wr_data         (o_wr_data),
      .i_wr_ready        (i_wr_ready),
      .o_idle            (o_idle)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_wr(input string tag, input bit ev,
                            input int a, input int d);
      check({tag, "_valid"}, o_wr_valid, ev);
      if (ev) begin
         check({tag, "_addr"}, o_wr_addr, a);
         check({tag, "_data"}, o_wr_data, d);
      end
   endtask

   function automatic logic [95:0] mk_vec(input int hi);
      logic [95:0] v;
      for (int k = 0; k < 6; k++)
         v[k*16 +: 16] = 16'((hi << 8) | (k + 1));
      return v;
   endfunction

   task automatic do_reset();
      i_reset       = 1'b1;
      i_issue_valid = 1'b0;
      i_acc_data    = '1;
      i_wr_ready    = 1'b1;
      @(posedge i_clock); #1;
      @(negedge i_clock);
      check("rst_ready", o_issue_ready, 0);
      check("rst_valid", o_wr_valid, 0);
      check("rst_addr", o_wr_addr, 0);
      check("rst_data", o_wr_data, 0);
      check("rst_idle", o_idle, 1);
      @(posedge i_clock); #1;
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset           = 1'b1;
      i_issue_valid     = 1'b0;
      i_issue_base_addr = '0;
      i_acc_data        = '1;
      i_wr_ready        = 1'b1;

      // single vector
      do_reset();
      for (int c = 0; c < 14; c++) begin
         i_issue_valid     = (c == 0);
         i_issue_base_addr = 10'h010;
         i_acc_data        = (c == 4) ? mk_vec(0) : '1;
         @(negedge i_clock);
         if (c == 0) check("s1_ready", o_issue_ready, 1);
         expect_wr("s1", c >= 5 && c <= 10, 'h10 + c - 5, c - 4);
         check("s1_idle", o_idle, c >= 11);
         @(posedge i_clock); #1;
      end

      // address wrap
      do_reset();
      for (int c = 0; c < 13; c++) begin
         i_issue_valid     = (c == 0);
         i_issue_base_addr = 10'h3FE;
         i_acc_data        = (c == 4) ? mk_vec('h31) : '1;
         @(negedge i_clock);
         expect_wr("s2", c >= 5 && c <= 10, ('h3FE + c - 5) & 'h3FF,
                   'h3100 | (c - 4));
         @(posedge i_clock); #1;
      end

      // credit limit with ignored issues while full
      do_reset();
      hits = 0;
      for (int c = 0; c < 33; c++) begin
         i_issue_valid     = (c <= 10);
         i_issue_base_addr = (c < 4) ? 10'(('h200 + c * 16)) : 10'h100;
         i_acc_data        = (c >= 4 && c <= 7) ? mk_vec(c - 4) : '1;
         @(negedge i_clock);
         if (c <= 11) check("s3_ready", o_issue_ready, c < 4 || c == 11);
         ev_i = (c - 5) / 6;
         ev_k = (c - 5) % 6;
         expect_wr("s3", c >= 5 && c <= 28, 'h200 + ev_i * 16 + ev_k,
                   (ev_i << 8) | (ev_k + 1));
         if (o_wr_valid && o_wr_addr == 10'h100) hits++;
         @(posedge i_clock); #1;
      end
      check("s5_no_0x100", hits, 0);

      // backpressure
      do_reset();
      for (int c = 0; c < 17; c++) begin
         i_issue_valid     = (c == 0);
         i_issue_base_addr = 10'h010;
         i_acc_data        = (c == 4) ? mk_vec(0) : '1;
         i_wr_ready        = !(c >= 6 && c <= 9);
         @(negedge i_clock);
         ev_k = (c == 5) ? 0 : (c <= 10) ? 1 : c - 9;
         expect_wr("s4", c >= 5 && c <= 14, 'h10 + ev_k, ev_k + 1);
         @(posedge i_clock); #1;
      end
      i_wr_ready = 1'b1;

      // reset mid-operation
      do_reset();
      for (int c = 0; c < 22; c++) begin
         i_reset           = (c == 7);
         i_issue_valid     = (c == 0) || (c == 9);
         i_issue_base_addr = (c == 0) ? 10'h010 : 10'h020;
         i_acc_data        = (c == 4) ? mk_vec(0) :
                             (c == 13) ? mk_vec('h77) : '1;
         @(negedge i_clock);
         if (c == 8) check("s6_idle", o_idle, 1);
         if (c == 9) check("s6_ready", o_issue_ready, 1);
         if (c != 7)
            expect_wr("s6", c == 5 || c == 6 || (c >= 14 && c <= 19),
                      (c < 7) ? 'h10 + c - 5 : 'h20 + c - 14,
                      (c < 7) ? c - 4 : 'h7700 | (c - 13));
         @(posedge i_clock); #1;
      end
      i_reset = 1'b0;
      @(negedge i_clock);
      check("end_idle", o_idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
